// File: rtl/wash_pkg.sv
// Shared state encoding, display codes and BCD helper for the wash setup controller.
package wash_pkg;

  typedef enum logic [1:0] {
    S_BAL,
    S_MODE,
    S_WEIGHT,
    S_ALARM
  } state_t;

  localparam logic [3:0] MINUS      = 4'hA;
  localparam logic [3:0] BLANK      = 4'hB;
  localparam logic [3:0] LID_CLOSED = 4'hC;
  localparam logic [3:0] ALARM_A    = 4'hA;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/wash_bcd_counter.sv
// One BCD digit, 9 wraps to 0; synchronous clear wins over increment.
module wash_bcd_counter
  import wash_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= bcd_inc(q);
  end

endmodule

// File: rtl/wash_setup_ctrl.sv
// Wash machine setup sequencer: balance entry, mode select, load weight, overload alarm.
// disp is registered, so it follows the controller state with one cycle of latency.
module wash_setup_ctrl
  import wash_pkg::*;
#(
  parameter int                 NDIG     = 3,
  parameter int                 NMODE    = 4,
  parameter logic [8*NMODE-1:0] WMAX_TBL = {8'd20, 8'd9, 8'd19, 8'd20},
  parameter int                 TICK     = 66_000_000,
  parameter int                 BLINK    = 50_000_000,
  parameter int                 NBLINK   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     on,
  input  logic [NDIG-1:0]          dig_up,
  input  logic                     sign,
  input  logic                     ten_sel,
  input  logic                     btn_r,
  input  logic                     btn_d,
  input  logic                     btn_m,
  input  logic                     btn_u,
  output logic [4*NDIG-1:0]        bal,
  output logic [$clog2(NMODE)-1:0] mode,
  output logic [6:0]               weight,
  output logic                     is_on,
  output logic                     done,
  output logic [2:0]               st_light,
  output logic                     lid_open,
  output logic [31:0]              disp
);

  localparam int MW = $clog2(NMODE);
  localparam int TW = $clog2(TICK + 1);
  localparam int BW = $clog2(BLINK + 1);
  localparam int HW = $clog2(NBLINK + 1);

  state_t                 state, state_nx;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          blink_cnt;
  logic [HW-1:0]          half_cnt;
  logic [NDIG-1:0][3:0]   digits;
  logic                   neg;
  logic [MW-1:0]          sel;
  logic [6:0]             w_work;
  logic [6:0]             w_step;
  logic [7:0]             w_sum;
  logic [7:0]             wmax;
  logic [31:0]            disp_nx;
  logic                   tick, half_end, alarm_end, bal_ok;
  logic                   load_bal, clr_dig, sel_clr, sel_inc, commit_mode;
  logic                   lid_tgl, w_up, w_dn, commit_w;

  assign tick      = (tick_cnt == TW'(TICK - 1));
  assign half_end  = (blink_cnt == BW'(BLINK - 1));
  assign alarm_end = half_end && (half_cnt == HW'(NBLINK - 1));
  assign bal_ok    = (dig_up == '0) && !sign && !neg;
  assign wmax      = WMAX_TBL[8*mode +: 8];
  assign is_on     = (state == S_WEIGHT) && !lid_open && ({1'b0, w_work} <= wmax);
  assign w_step    = ten_sel ? 7'd10 : 7'd1;
  assign w_sum     = {1'b0, w_work} + {1'b0, w_step};

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    wash_bcd_counter u_digit (
      .clk (clk),
      .rst (rst),
      .clr (on && clr_dig),
      .inc (on && tick && (state == S_BAL) && dig_up[g] && !clr_dig),
      .q   (digits[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    state <= S_BAL;
    else if (on) state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    st_light    = 3'b000;
    load_bal    = 1'b0;
    clr_dig     = 1'b0;
    sel_clr     = 1'b0;
    sel_inc     = 1'b0;
    commit_mode = 1'b0;
    lid_tgl     = 1'b0;
    w_up        = 1'b0;
    w_dn        = 1'b0;
    commit_w    = 1'b0;
    case (state)
      S_BAL: begin
        st_light = 3'b001;
        if (btn_m) begin
          if (bal_ok) begin
            load_bal = 1'b1;
            sel_clr  = 1'b1;
            state_nx = S_MODE;
          end else begin
            clr_dig = 1'b1;
          end
        end
      end
      S_MODE: begin
        st_light = 3'b010;
        if (btn_m) begin
          commit_mode = 1'b1;
          state_nx    = S_WEIGHT;
        end else if (btn_r) begin
          sel_inc = 1'b1;
        end
      end
      S_WEIGHT: begin
        st_light = 3'b100;
        lid_tgl  = btn_u;
        // confirm looks at the lid state before any same-cycle toggle
        if (btn_m && !lid_open) begin
          if (is_on) begin
            commit_w = 1'b1;
            clr_dig  = 1'b1;
            state_nx = S_BAL;
          end else begin
            state_nx = S_ALARM;
          end
        end else if (lid_open) begin
          w_up = btn_r;
          w_dn = btn_d && !btn_r;
        end
      end
      S_ALARM: begin
        if (alarm_end) begin
          sel_clr  = 1'b1;
          state_nx = S_MODE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    disp_nx = {8{BLANK}};
    case (state)
      S_BAL: begin
        for (int unsigned i = 0; i < NDIG; i++) disp_nx[4*i +: 4] = digits[i];
        if (NDIG < 4 && neg) disp_nx[4*NDIG +: 4] = MINUS;
        disp_nx[31:28] = LID_CLOSED;
      end
      S_MODE: disp_nx[3:0] = 4'(sel);
      S_WEIGHT: begin
        disp_nx[3:0]   = 4'(w_work % 7'd10);
        disp_nx[7:4]   = 4'(w_work / 7'd10);
        disp_nx[15:12] = 4'(mode);
        disp_nx[31:28] = lid_open ? BLANK : LID_CLOSED;
      end
      S_ALARM: if (half_cnt[0]) disp_nx[19:0] = {ALARM_A, MINUS, 4'(mode), MINUS, 4'd9};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt  <= '0;
      blink_cnt <= '0;
      half_cnt  <= '0;
      neg       <= 1'b0;
      bal       <= '0;
      sel       <= '0;
      mode      <= '0;
      w_work    <= '0;
      weight    <= '0;
      lid_open  <= 1'b0;
      done      <= 1'b0;
      disp      <= {8{BLANK}};
    end else if (on) begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (clr_dig)                           neg <= 1'b0;
      else if (state == S_BAL && tick && sign) neg <= ~neg;
      if (load_bal) bal <= digits;
      if (sel_clr)      sel <= '0;
      else if (sel_inc) sel <= (sel == MW'(NMODE - 1)) ? '0 : sel + MW'(1);
      if (commit_mode) begin
        mode     <= sel;
        lid_open <= 1'b1;
        w_work   <= '0;
      end else begin
        if (lid_tgl) lid_open <= ~lid_open;
        if (w_up)      w_work <= (w_sum > 8'd99) ? 7'd99 : w_sum[6:0];
        else if (w_dn) w_work <= (w_work < w_step) ? '0 : w_work - w_step;
      end
      if (commit_w) weight <= w_work;
      done <= commit_w;
      if (state == S_ALARM) begin
        if (half_end) begin
          blink_cnt <= '0;
          half_cnt  <= alarm_end ? '0 : half_cnt + HW'(1);
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end else begin
        blink_cnt <= '0;
        half_cnt  <= '0;
      end
      disp <= disp_nx;
    end
  end

endmodule

// File: tb/tb_wash_setup_ctrl.sv
// Self-checking bench for wash_setup_ctrl: scoreboard of timed expectations plus a vector table.
module tb_wash_setup_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        on = 1'b1;
  logic [2:0]  dig_up = '0;
  logic        sign = 1'b0, ten_sel = 1'b0;
  logic        btn_r = 1'b0, btn_d = 1'b0, btn_m = 1'b0, btn_u = 1'b0;
  logic [11:0] bal;
  logic [1:0]  mode;
  logic [6:0]  weight;
  logic        is_on, done, lid_open;
  logic [2:0]  st_light;
  logic [31:0] disp;

  wash_setup_ctrl #(
    .NDIG     (3),
    .NMODE    (4),
    .WMAX_TBL ({8'd20, 8'd9, 8'd19, 8'd20}),
    .TICK     (4),
    .BLINK    (3),
    .NBLINK   (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .on       (on),
    .dig_up   (dig_up),
    .sign     (sign),
    .ten_sel  (ten_sel),
    .btn_r    (btn_r),
    .btn_d    (btn_d),
    .btn_m    (btn_m),
    .btn_u    (btn_u),
    .bal      (bal),
    .mode     (mode),
    .weight   (weight),
    .is_on    (is_on),
    .done     (done),
    .st_light (st_light),
    .lid_open (lid_open),
    .disp     (disp)
  );

  always #5 clk = ~clk;

  localparam int K_DISP = 0, K_ST = 1, K_LID = 2, K_ISON = 3, K_W = 4, K_MODE = 5, K_BAL = 6, K_DONE = 7;

  typedef struct {
    string       nm;
    int          kind;
    logic [31:0] val;
    int unsigned due;
  } sb_t;

  typedef struct {
    logic        r, d, u, m, ten;
    logic        lid, ison;
    logic [2:0]  st;
    logic [31:0] dsp;
  } vec_t;

  sb_t         sb[$];
  vec_t        vt[9];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] out_of(input int kind);
    case (kind)
      K_DISP: return disp;
      K_ST:   return 32'(st_light);
      K_LID:  return 32'(lid_open);
      K_ISON: return 32'(is_on);
      K_W:    return 32'(weight);
      K_MODE: return 32'(mode);
      K_BAL:  return 32'(bal);
      K_DONE: return 32'(done);
      default: return '0;
    endcase
  endfunction

  task automatic push(input string nm, input int kind, input logic [31:0] v, input int unsigned lat);
    sb_t e;
    e.nm = nm; e.kind = kind; e.val = v; e.due = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].nm, out_of(sb[i].kind), sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  task automatic release_btns();
    btn_r = 1'b0; btn_d = 1'b0; btn_m = 1'b0; btn_u = 1'b0; ten_sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 32'hBBBB1B10};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 32'hBBBB1B20};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 32'hBBBB1B19};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 32'hCBBB1B19};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 32'hCBBB1B19};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 32'hBBBB1B19};
    vt[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 32'hBBBB1B20};
    vt[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 32'hCBBB1B20};
    vt[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'hBBBBBBBB};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_st", 32'(st_light), 32'h1);
    check("rst_bal", 32'(bal), 32'h0);
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_weight", 32'(weight), 32'h0);
    check("rst_is_on", 32'(is_on), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_lid", 32'(lid_open), 32'h0);
    check("rst_disp_upper", 32'(disp[31:16]), 32'hBBBB);
    rst = 1'b1;

    // negative balance refuses confirm and clears
    sign = 1'b1;
    repeat (4) step();
    sign = 1'b0;
    push("neg_disp", K_DISP, 32'hCBBBA000, 2);
    step(); step();
    btn_m = 1'b1;
    push("neg_confirm_st", K_ST, 32'h1, 1);
    push("neg_cleared_disp", K_DISP, 32'hCBBBB000, 2);
    step(); release_btns(); step();

    // confirm with a switch high is also refused
    dig_up = 3'b100; btn_m = 1'b1;
    push("sw_confirm_st", K_ST, 32'h1, 1);
    push("sw_cleared_disp", K_DISP, 32'hCBBBB000, 2);
    step(); dig_up = '0; release_btns(); step();

    // balance entry: two ticks in eight cycles
    dig_up = 3'b001;
    repeat (8) step();
    dig_up = '0;
    push("bal_disp", K_DISP, 32'hCBBBB002, 2);
    step(); step();
    btn_m = 1'b1;
    push("bal_to_mode_st", K_ST, 32'h2, 1);
    push("bal_loaded", K_BAL, 32'h002, 1);
    push("mode_sel0_disp", K_DISP, 32'hBBBBBBB0, 2);
    step(); release_btns(); step();

    btn_r = 1'b1;
    push("mode_sel1_disp", K_DISP, 32'hBBBBBBB1, 2);
    step(); release_btns(); step();
    btn_m = 1'b1;
    push("mode1_commit_st", K_ST, 32'h4, 1);
    push("mode1_commit", K_MODE, 32'h1, 1);
    push("mode1_lid", K_LID, 32'h1, 1);
    push("mode1_is_on", K_ISON, 32'h0, 1);
    push("mode1_w0_disp", K_DISP, 32'hBBBB1B00, 2);
    step(); release_btns(); step();

    // weight adjust, lid handling and overload entry
    for (int i = 0; i < 9; i++) begin
      btn_r = vt[i].r; btn_d = vt[i].d; btn_u = vt[i].u; btn_m = vt[i].m; ten_sel = vt[i].ten;
      push($sformatf("vec%0d_lid", i), K_LID, 32'(vt[i].lid), 1);
      push($sformatf("vec%0d_is_on", i), K_ISON, 32'(vt[i].ison), 1);
      push($sformatf("vec%0d_st", i), K_ST, 32'(vt[i].st), 1);
      push($sformatf("vec%0d_disp", i), K_DISP, vt[i].dsp, 2);
      step();
      release_btns();
    end

    // alarm blink sequence, buttons ignored
    for (int kk = 1; kk <= 18; kk++) begin
      if (kk == 5) begin btn_r = 1'b1; btn_m = 1'b1; btn_u = 1'b1; end
      push($sformatf("alarm_st_k%0d", kk), K_ST, (kk == 18) ? 32'h2 : 32'h0, 1);
      if (kk == 5) push("alarm_lid_ignored", K_LID, 32'h0, 1);
      if (kk >= 2)
        push($sformatf("alarm_disp_k%0d", kk), K_DISP,
             (((kk - 1) / 3) % 2 == 1) ? 32'hBBBAA1A9 : 32'hBBBBBBBB, 1);
      step();
      release_btns();
    end
    push("alarm_exit_sel0_disp", K_DISP, 32'hBBBBBBB0, 1);
    step();

    // saturation in mode 3
    repeat (3) begin btn_r = 1'b1; step(); release_btns(); end
    btn_m = 1'b1;
    push("mode3_commit", K_MODE, 32'h3, 1);
    push("mode3_lid", K_LID, 32'h1, 1);
    step(); release_btns();
    btn_d = 1'b1;
    push("w_floor_disp", K_DISP, 32'hBBBB3B00, 2);
    step(); release_btns();
    repeat (10) begin ten_sel = 1'b1; btn_r = 1'b1; step(); release_btns(); end
    btn_r = 1'b1;
    push("w_ceiling_disp", K_DISP, 32'hBBBB3B99, 2);
    step(); release_btns();
    ten_sel = 1'b1; btn_d = 1'b1;
    push("w_99_minus_10_disp", K_DISP, 32'hBBBB3B89, 2);
    step(); release_btns();
    btn_u = 1'b1;
    push("w89_lid", K_LID, 32'h0, 1);
    push("w89_is_on", K_ISON, 32'h0, 1);
    step(); release_btns();
    btn_m = 1'b1;
    push("alarm2_st", K_ST, 32'h0, 1);
    step(); release_btns();
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (st_light == 3'b010) begin k = i; break; end
    end
    check("alarm2_length", 32'(k), 32'd18);

    // commit path in mode 0
    btn_m = 1'b1;
    push("mode0_commit", K_MODE, 32'h0, 1);
    push("mode0_lid", K_LID, 32'h1, 1);
    push("mode0_st", K_ST, 32'h4, 1);
    step(); release_btns();
    ten_sel = 1'b1; btn_r = 1'b1; step(); release_btns();
    repeat (5) begin btn_r = 1'b1; step(); release_btns(); end
    btn_u = 1'b1;
    push("w15_lid", K_LID, 32'h0, 1);
    push("w15_is_on", K_ISON, 32'h1, 1);
    push("w15_disp", K_DISP, 32'hCBBB0B15, 2);
    step(); release_btns();
    btn_m = 1'b1;
    push("commit_st", K_ST, 32'h1, 1);
    push("commit_weight", K_W, 32'd15, 1);
    push("commit_done_hi", K_DONE, 32'h1, 1);
    push("commit_is_on_off", K_ISON, 32'h0, 1);
    push("commit_done_lo", K_DONE, 32'h0, 2);
    push("commit_bal_disp", K_DISP, 32'hCBBBB000, 2);
    step(); release_btns(); step();

    // reset during alarm
    btn_m = 1'b1;
    push("bal0_to_mode_st", K_ST, 32'h2, 1);
    push("bal0_loaded", K_BAL, 32'h000, 1);
    step(); release_btns();
    repeat (2) begin btn_r = 1'b1; step(); release_btns(); end
    btn_m = 1'b1;
    push("mode2_commit", K_MODE, 32'h2, 1);
    step(); release_btns();
    ten_sel = 1'b1; btn_r = 1'b1; step(); release_btns();
    btn_u = 1'b1;
    push("w10_mode2_is_on", K_ISON, 32'h0, 1);
    step(); release_btns();
    btn_m = 1'b1;
    push("alarm3_st", K_ST, 32'h0, 1);
    step(); release_btns();
    repeat (3) step();
    push("alarm3_disp_k4", K_DISP, 32'hBBBAA2A9, 1);
    step();
    #2;
    rst = 1'b0;
    #1;
    check("arst_st", 32'(st_light), 32'h1);
    check("arst_disp", disp, 32'hBBBBBBBB);
    check("arst_mode", 32'(mode), 32'h0);
    check("arst_weight", 32'(weight), 32'h0);
    check("arst_bal", 32'(bal), 32'h0);
    check("arst_lid", 32'(lid_open), 32'h0);
    repeat (2) begin
      step();
      check("arst_hold_disp", disp, 32'hBBBBBBBB);
      check("arst_hold_st", 32'(st_light), 32'h1);
    end
    rst = 1'b1;

    // enable low holds everything
    on = 1'b0; btn_m = 1'b1;
    push("off_hold_st", K_ST, 32'h1, 1);
    step(); release_btns(); on = 1'b1;
    step(); step();
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
